dma_bus_master: RTL and testbench
=================================

DMA_BUS_MASTER -- requirements
Module: dma_bus_master

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: reg_cs  in  1  register-window select from CPU-side address decode.
REQ-004 SHALL have ports: reg_addr  in  4  register index.
REQ-005 SHALL have ports: reg_write  in  1  CPU write strobe; qualified by reg_cs and ready.
REQ-006 SHALL have ports: reg_data_i  in  8  CPU write data.
REQ-007 SHALL have ports: reg_data_o  out  8  register read data, combinational from reg_addr.
REQ-008 SHALL have ports: bus_req  out  1  high while a job runs; the system holds the CPU off the bus.
REQ-009 SHALL have ports: ready  in  1  bus ready; a presented cycle is accepted on a rising clk edge with ready=1.
REQ-010 SHALL have ports: address_next  out  20  bus address for the cycle presented now.
REQ-011 SHALL have ports: write_next  out  1  1=write cycle, 0=read cycle.
REQ-012 SHALL have ports: data_o_next  out  8  write data, valid with write_next=1.
REQ-013 SHALL have ports: data_i  in  8  read data, valid the cycle after the accepting edge (synchronous RAM).
REQ-014 SHALL have ports: done_irq  out  1  one-cycle pulse at job completion.

Function
REQ-015 SHALL implement registers: 0-2 SRC[19:0] (reg2 bits 3:0), 3-5 DST[19:0], 6-7 COUNT[15:0] little-endian, 8 CMD, 9 FILL value.
REQ-016 SHALL decode CMD bits: 0 fill mode, 1 source hold (no increment), 2 destination hold; bits 7:3 ignored.
REQ-017 SHALL start a job on the accepted write to reg 8 while idle; bus_req rises on the following edge.
REQ-018 SHALL ignore all register writes while bus_req=1.
REQ-019 SHALL read back reg 8 as {busy, 4'b0, CMD[2:0]}; other regs return current working values; unused indices read 0x00.
REQ-020 SHALL treat COUNT=0 as 65536 bytes.
REQ-021 SHALL use FSM states IDLE, READ, CAPTURE, WRITE, DONE.
REQ-022 IDLE: address_next=0, write_next=0, data_o_next=0, bus_req=0; start -> READ (copy) or WRITE (fill).
REQ-023 READ: present SRC, write_next=0; hold until ready=1, then -> CAPTURE.
REQ-024 CAPTURE: latch data_i into holding register, no bus cycle presented (write_next=0), -> WRITE unconditionally.
REQ-025 WRITE: present DST, write_next=1, data_o_next = holding reg (copy) or FILL (fill); hold until ready=1.
REQ-026 On accepted WRITE: decrement COUNT, advance SRC/DST by 1 unless held; COUNT reaching 0 -> DONE, else -> READ (copy) or WRITE (fill).
REQ-027 Address arithmetic SHALL be 20-bit modulo: 0xFFFFF+1 = 0x00000; COUNT decrement 16-bit modulo (0 -> 0xFFFF on first byte of a 65536 job).
REQ-028 DONE: done_irq=1 and bus_req=0 for exactly one cycle, -> IDLE; SRC/DST/COUNT keep final values.
REQ-029 Throughput with ready held 1: copy 3 cycles/byte, fill 1 cycle/byte.
REQ-030 Address, write_next and data_o_next SHALL remain stable while ready=0 in READ or WRITE.

Reset
REQ-031 reset=0 SHALL immediately force IDLE, all registers 0x00, bus_req=0, done_irq=0, write_next=0, address_next=0, data_o_next=0, including mid-job; no partial write completes after reset asserts.

Verification
REQ-032 Fill: FILL=0x5A, DST=0x00800, COUNT=4, CMD=0x01, ready=1 -> writes 0x5A at 0x00800..0x00803 on 4 consecutive edges, done_irq one cycle later, COUNT reads 0.
REQ-033 Copy: SRC=0x01000 holding 11,22,33, DST=0x02000, COUNT=3, CMD=0x00 -> 0x02000..2 = 11,22,33, 9 bus cycles, one done_irq pulse.
REQ-034 Ready stress: ready toggling every cycle during copy -> identical memory result, outputs stable on every ready=0 cycle.
REQ-035 Wrap/hold: DST=0xFFFFF, COUNT=2, fill, CMD=0x01 -> writes 0xFFFFF then 0x00000; repeat with CMD=0x05 -> both writes to 0xFFFFF.
REQ-036 Reset mid-job: drop reset during WRITE of byte 2 of 5 -> bus_req=0, write_next=0 immediately, reg reads 0x00, no further bus cycles.
REQ-037 Busy lockout: write SRC during a job -> value unchanged; reg 8 reads 0x80|CMD while busy, CMD only after done.

Source files
------------

// File: rtl/dma_bus_master.sv
// Single-channel byte DMA engine: CPU-programmed copy or fill over a simple
// ready-handshaked bus with synchronous-read memory behind it.
module dma_bus_master (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_cs,
    input  logic [3:0]  reg_addr,
    input  logic        reg_write,
    input  logic [7:0]  reg_data_i,
    output logic [7:0]  reg_data_o,
    output logic        bus_req,
    input  logic        ready,
    output logic [19:0] address_next,
    output logic        write_next,
    output logic [7:0]  data_o_next,
    input  logic [7:0]  data_i,
    output logic        done_irq
);

    typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, DONE} state_t;

    state_t      state_reg;
    logic [19:0] src_reg;
    logic [19:0] dst_reg;
    logic [15:0] count_reg;
    logic [2:0]  cmd_reg;
    logic [7:0]  fill_reg;
    logic [19:0] address_reg;
    logic        write_reg;
    logic [7:0]  data_reg;
    logic        bus_req_reg;
    logic        done_reg;

    logic        reg_wr;
    logic [19:0] src_step;
    logic [19:0] dst_step;
    logic [15:0] count_dec;

    // CPU writes need ready as well, and are locked out for the whole job.
    assign reg_wr    = reg_cs && reg_write && ready && !bus_req_reg;
    assign src_step  = src_reg + (cmd_reg[1] ? 20'd0 : 20'd1);
    assign dst_step  = dst_reg + (cmd_reg[2] ? 20'd0 : 20'd1);
    assign count_dec = count_reg - 16'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            src_reg     <= 20'd0;
            dst_reg     <= 20'd0;
            count_reg   <= 16'd0;
            cmd_reg     <= 3'd0;
            fill_reg    <= 8'd0;
            address_reg <= 20'd0;
            write_reg   <= 1'b0;
            data_reg    <= 8'd0;
            bus_req_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;

            if (reg_wr) begin
                case (reg_addr)
                    4'd0: src_reg[7:0]     <= reg_data_i;
                    4'd1: src_reg[15:8]    <= reg_data_i;
                    4'd2: src_reg[19:16]   <= reg_data_i[3:0];
                    4'd3: dst_reg[7:0]     <= reg_data_i;
                    4'd4: dst_reg[15:8]    <= reg_data_i;
                    4'd5: dst_reg[19:16]   <= reg_data_i[3:0];
                    4'd6: count_reg[7:0]   <= reg_data_i;
                    4'd7: count_reg[15:8]  <= reg_data_i;
                    4'd8: cmd_reg          <= reg_data_i[2:0];
                    4'd9: fill_reg         <= reg_data_i;
                    default: ;
                endcase
            end

            case (state_reg)
                IDLE: begin
                    if (reg_wr && reg_addr == 4'd8) begin
                        bus_req_reg <= 1'b1;
                        if (reg_data_i[0]) begin
                            state_reg   <= WRITE;
                            address_reg <= dst_reg;
                            write_reg   <= 1'b1;
                            data_reg    <= fill_reg;
                        end else begin
                            state_reg   <= READ;
                            address_reg <= src_reg;
                        end
                    end
                end
                READ: begin
                    if (ready) begin
                        state_reg   <= CAPTURE;
                        address_reg <= 20'd0;
                    end
                end
                CAPTURE: begin
                    // data_reg doubles as the holding register for the copied byte
                    state_reg   <= WRITE;
                    address_reg <= dst_reg;
                    write_reg   <= 1'b1;
                    data_reg    <= data_i;
                end
                WRITE: begin
                    if (ready) begin
                        src_reg   <= src_step;
                        dst_reg   <= dst_step;
                        count_reg <= count_dec;
                        if (count_dec == 16'd0) begin
                            state_reg   <= DONE;
                            bus_req_reg <= 1'b0;
                            done_reg    <= 1'b1;
                            address_reg <= 20'd0;
                            write_reg   <= 1'b0;
                            data_reg    <= 8'd0;
                        end else if (cmd_reg[0]) begin
                            address_reg <= dst_step;
                            data_reg    <= fill_reg;
                        end else begin
                            state_reg   <= READ;
                            address_reg <= src_step;
                            write_reg   <= 1'b0;
                            data_reg    <= 8'd0;
                        end
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus_req      = bus_req_reg;
    assign address_next = address_reg;
    assign write_next   = write_reg;
    assign data_o_next  = data_reg;
    assign done_irq     = done_reg;

    always_comb begin
        reg_data_o = 8'h00;
        case (reg_addr)
            4'd0: reg_data_o = src_reg[7:0];
            4'd1: reg_data_o = src_reg[15:8];
            4'd2: reg_data_o = {4'b0, src_reg[19:16]};
            4'd3: reg_data_o = dst_reg[7:0];
            4'd4: reg_data_o = dst_reg[15:8];
            4'd5: reg_data_o = {4'b0, dst_reg[19:16]};
            4'd6: reg_data_o = count_reg[7:0];
            4'd7: reg_data_o = count_reg[15:8];
            4'd8: reg_data_o = {bus_req_reg, 4'b0, cmd_reg};
            4'd9: reg_data_o = fill_reg;
            default: reg_data_o = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_dma_bus_master.sv
// Directed bench for dma_bus_master: a byte memory model answers bus cycles,
// each task programs one job and checks the result against hand-worked values.
module tb_dma_bus_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reg_cs = 1'b0;
    logic [3:0]  reg_addr = 4'd0;
    logic        reg_write = 1'b0;
    logic [7:0]  reg_data_i = 8'd0;
    logic [7:0]  reg_data_o;
    logic        bus_req;
    logic        ready = 1'b1;
    logic [19:0] address_next;
    logic        write_next;
    logic [7:0]  data_o_next;
    logic [7:0]  data_i;
    logic        done_irq;

    int checks = 0;
    int failures = 0;

    dma_bus_master dut (
        .clk(clk), .reset(reset), .reg_cs(reg_cs), .reg_addr(reg_addr),
        .reg_write(reg_write), .reg_data_i(reg_data_i), .reg_data_o(reg_data_o),
        .bus_req(bus_req), .ready(ready), .address_next(address_next),
        .write_next(write_next), .data_o_next(data_o_next), .data_i(data_i),
        .done_irq(done_irq)
    );

    always #5 clk = ~clk;

    // Bus-side memory with one-cycle read latency, plus a log of accepted writes.
    logic [7:0]  mem [logic [19:0]];
    logic [7:0]  rd_data = 8'h00;
    int          cyc = 0;
    int          busy_cycles = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          wl_cyc[$];
    logic [19:0] wl_addr[$];
    logic [7:0]  wl_data[$];

    assign data_i = rd_data;

    always @(posedge clk) begin
        if (reset && bus_req && ready) begin
            if (write_next) begin
                mem[address_next] = data_o_next;
                wl_cyc.push_back(cyc);
                wl_addr.push_back(address_next);
                wl_data.push_back(data_o_next);
            end else begin
                rd_data <= mem.exists(address_next) ? mem[address_next] : 8'h00;
            end
        end
        if (bus_req) busy_cycles++;
        if (done_irq) begin
            done_cnt++;
            done_cyc = cyc;
        end
        cyc++;
    end

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        reg_cs = 1'b1; reg_write = 1'b1; reg_addr = a; reg_data_i = d;
        @(negedge clk);
        reg_cs = 1'b0; reg_write = 1'b0;
    endtask

    task automatic rdreg(input logic [3:0] a, output logic [7:0] v);
        reg_addr = a;
        #1;
        v = reg_data_o;
    endtask

    task automatic program_job(input logic [19:0] src, input logic [19:0] dst,
                               input logic [15:0] count, input logic [7:0] fill);
        wr(4'd0, src[7:0]);  wr(4'd1, src[15:8]);  wr(4'd2, {4'b0, src[19:16]});
        wr(4'd3, dst[7:0]);  wr(4'd4, dst[15:8]);  wr(4'd5, {4'b0, dst[19:16]});
        wr(4'd6, count[7:0]); wr(4'd7, count[15:8]);
        wr(4'd9, fill);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int start;
        start = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt > start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_log();
        wl_cyc.delete(); wl_addr.delete(); wl_data.delete();
    endtask

    task automatic test_reset();
        logic [7:0] v;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_req, done_irq, write_next, address_next, data_o_next} !== 31'd0) begin
            failures++;
            $display("FAIL reset_outputs: got bus_req=%b done=%b wr=%b addr=%05h data=%02h required all 0",
                     bus_req, done_irq, write_next, address_next, data_o_next);
        end
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            rdreg(i[3:0], v);
            checks++;
            if (v !== 8'h00) begin
                failures++;
                $display("FAIL reset_reg[%0d]: got %02h required 00", i, v);
            end
        end
    endtask

    task automatic test_fill();
        logic [7:0] v;
        bit ok;
        int d0, start_cyc;
        program_job(20'h0, 20'h00800, 16'd4, 8'h5A);
        clear_log();
        d0 = done_cnt;
        wr(4'd8, 8'h01);
        start_cyc = cyc;
        checks++;
        if (bus_req !== 1'b1) begin
            failures++; $display("FAIL fill_busreq: got %b required 1", bus_req);
        end
        rdreg(4'd8, v);
        checks++;
        if (v !== 8'h81) begin
            failures++; $display("FAIL fill_busy_cmd: got %02h required 81", v);
        end
        wait_done(50, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL fill_timeout: got no done_irq required one");
        end
        checks++;
        if (wl_addr.size() != 4) begin
            failures++; $display("FAIL fill_write_count: got %0d required 4", wl_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wl_addr[i] !== 20'h00800 + 20'(i) || wl_data[i] !== 8'h5A
                    || wl_cyc[i] != start_cyc + i) begin
                    failures++;
                    $display("FAIL fill_write[%0d]: got addr=%05h data=%02h cyc=%0d required addr=%05h data=5a cyc=%0d",
                             i, wl_addr[i], wl_data[i], wl_cyc[i], 20'h00800 + 20'(i), start_cyc + i);
                end
            end
            checks++;
            if (done_cyc != wl_cyc[3] + 1) begin
                failures++; $display("FAIL fill_done_timing: got cyc %0d required %0d", done_cyc, wl_cyc[3] + 1);
            end
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++; $display("FAIL fill_done_pulses: got %0d required 1", done_cnt - d0);
        end
        rdreg(4'd6, v);
        checks++;
        if (v !== 8'h00) begin failures++; $display("FAIL fill_count_lo: got %02h required 00", v); end
        rdreg(4'd7, v);
        checks++;
        if (v !== 8'h00) begin failures++; $display("FAIL fill_count_hi: got %02h required 00", v); end
        rdreg(4'd8, v);
        checks++;
        if (v !== 8'h01) begin failures++; $display("FAIL fill_cmd_idle: got %02h required 01", v); end
        rdreg(4'd3, v);
        checks++;
        if (v !== 8'h04) begin failures++; $display("FAIL fill_dst_final: got %02h required 04", v); end
    endtask

    task automatic test_copy_lockout();
        logic [7:0] v;
        logic [7:0] exp_data [3];
        bit ok;
        int d0, b0;
        exp_data[0] = 8'h11; exp_data[1] = 8'h22; exp_data[2] = 8'h33;
        for (int i = 0; i < 3; i++) mem[20'h01000 + 20'(i)] = exp_data[i];
        program_job(20'h01000, 20'h02000, 16'd3, 8'h00);
        clear_log();
        d0 = done_cnt;
        b0 = busy_cycles;
        wr(4'd8, 8'h00);
        rdreg(4'd8, v);
        checks++;
        if (v !== 8'h80) begin failures++; $display("FAIL copy_busy_cmd: got %02h required 80", v); end
        wr(4'd0, 8'hFF);
        wait_done(100, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL copy_timeout: got no done_irq required one"); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem[20'h02000 + 20'(i)] !== exp_data[i]) begin
                failures++;
                $display("FAIL copy_mem[%0d]: got %02h required %02h", i, mem[20'h02000 + 20'(i)], exp_data[i]);
            end
        end
        checks++;
        if (busy_cycles - b0 != 9) begin
            failures++; $display("FAIL copy_bus_cycles: got %0d required 9", busy_cycles - b0);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++; $display("FAIL copy_done_pulses: got %0d required 1", done_cnt - d0);
        end
        rdreg(4'd0, v);
        checks++;
        if (v !== 8'h03) begin failures++; $display("FAIL copy_lockout_src: got %02h required 03", v); end
        rdreg(4'd1, v);
        checks++;
        if (v !== 8'h10) begin failures++; $display("FAIL copy_src_mid: got %02h required 10", v); end
        rdreg(4'd8, v);
        checks++;
        if (v !== 8'h00) begin failures++; $display("FAIL copy_cmd_idle: got %02h required 00", v); end
    endtask

    task automatic test_ready_stress();
        logic [28:0] prev;
        logic [28:0] cur;
        bit have_prev;
        int ph, left;
        for (int i = 0; i < 3; i++) mem[20'h02000 + 20'(i)] = 8'h00;
        program_job(20'h01000, 20'h02000, 16'd3, 8'h00);
        wr(4'd8, 8'h00);
        ph = 1;          // 1 READ, 2 CAPTURE, 3 WRITE, 4 DONE
        left = 3;
        have_prev = 1'b0;
        prev = '0;
        for (int c = 0; c < 200 && ph != 4; c++) begin
            cur = {address_next, write_next, data_o_next};
            if (have_prev) begin
                checks++;
                if (cur !== prev) begin
                    failures++;
                    $display("FAIL stress_stable@%0d: got %08h required %08h", c, cur, prev);
                end
            end
            ready = (c % 2) == 1;
            have_prev = !ready && (ph == 1 || ph == 3);
            prev = cur;
            case (ph)
                1: if (ready) ph = 2;
                2: ph = 3;
                3: if (ready) begin left--; ph = (left == 0) ? 4 : 1; end
                default: ;
            endcase
            @(negedge clk);
        end
        ready = 1'b1;
        checks++;
        if (ph != 4 || done_irq !== 1'b1 || bus_req !== 1'b0) begin
            failures++;
            $display("FAIL stress_done: got phase=%0d done_irq=%b bus_req=%b required 4/1/0", ph, done_irq, bus_req);
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem[20'h02000 + 20'(i)] !== 8'h11 * 8'(i + 1)) begin
                failures++;
                $display("FAIL stress_mem[%0d]: got %02h required %02h", i, mem[20'h02000 + 20'(i)], 8'h11 * 8'(i + 1));
            end
        end
    endtask

    task automatic test_wrap_hold();
        logic [7:0] v;
        bit ok;
        program_job(20'h0, 20'hFFFFF, 16'd2, 8'hC3);
        clear_log();
        wr(4'd8, 8'h01);
        wait_done(50, ok);
        checks++;
        if (!ok || wl_addr.size() != 2) begin
            failures++; $display("FAIL wrap_writes: got %0d writes required 2", wl_addr.size());
        end else begin
            checks++;
            if (wl_addr[0] !== 20'hFFFFF || wl_addr[1] !== 20'h00000 || wl_data[1] !== 8'hC3) begin
                failures++;
                $display("FAIL wrap_addr: got %05h,%05h data %02h required fffff,00000 data c3",
                         wl_addr[0], wl_addr[1], wl_data[1]);
            end
        end
        rdreg(4'd3, v);
        checks++;
        if (v !== 8'h01) begin failures++; $display("FAIL wrap_dst_final: got %02h required 01", v); end
        program_job(20'h0, 20'hFFFFF, 16'd2, 8'hC3);
        clear_log();
        wr(4'd8, 8'h05);
        wait_done(50, ok);
        checks++;
        if (!ok || wl_addr.size() != 2) begin
            failures++; $display("FAIL hold_writes: got %0d writes required 2", wl_addr.size());
        end else begin
            checks++;
            if (wl_addr[0] !== 20'hFFFFF || wl_addr[1] !== 20'hFFFFF) begin
                failures++;
                $display("FAIL hold_addr: got %05h,%05h required fffff,fffff", wl_addr[0], wl_addr[1]);
            end
        end
        rdreg(4'd5, v);
        checks++;
        if (v !== 8'h0F) begin failures++; $display("FAIL hold_dst_hi: got %02h required 0f", v); end
        rdreg(4'd8, v);
        checks++;
        if (v !== 8'h05) begin failures++; $display("FAIL hold_cmd: got %02h required 05", v); end
    endtask

    task automatic test_reset_midjob();
        logic [7:0] v;
        program_job(20'h0, 20'h03000, 16'd5, 8'h77);
        clear_log();
        wr(4'd8, 8'h01);
        @(negedge clk);
        ready = 1'b0;
        #1;
        checks++;
        if (write_next !== 1'b1 || address_next !== 20'h03001) begin
            failures++;
            $display("FAIL midjob_setup: got wr=%b addr=%05h required 1/03001", write_next, address_next);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({bus_req, done_irq, write_next, address_next, data_o_next} !== 31'd0) begin
            failures++;
            $display("FAIL midjob_outputs: got bus_req=%b done=%b wr=%b addr=%05h data=%02h required all 0",
                     bus_req, done_irq, write_next, address_next, data_o_next);
        end
        for (int i = 0; i < 10; i++) begin
            rdreg(i[3:0], v);
            checks++;
            if (v !== 8'h00) begin
                failures++; $display("FAIL midjob_reg[%0d]: got %02h required 00", i, v);
            end
        end
        ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (wl_addr.size() != 1 || bus_req !== 1'b0 || mem.exists(20'h03001)) begin
            failures++;
            $display("FAIL midjob_no_more_cycles: got %0d writes bus_req=%b required 1 write bus_req=0",
                     wl_addr.size(), bus_req);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_copy_lockout();
        test_ready_stress();
        test_wrap_hold();
        test_reset_midjob();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
